// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and types, used by both the Gray counter source
// and the receive-side decoder/monitor.
package gray_pkg;

    // Default Gray/binary word width.
    localparam int GRAY_DEFAULT_W = 8;

    // Widest word the helper functions handle. Narrower words are passed
    // zero-extended. Zero upper bits leave the lower bits of both conversions
    // unchanged, so a caller simply truncates the result back to its own width.
    localparam int GRAY_MAX_W = 32;

    // Classification of one sampled change.
    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_SKIP = 2'd3
    } step_kind_e;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary to Gray: each Gray bit marks a change between adjacent binary bits.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-bit flop-chain synchronizer for Gray-coded (single-bit-change) buses.
// Every stage resets to zero asynchronously.
module gray_sync #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] stage_q [STAGES];
    logic [W-1:0] stage_d [STAGES];

    // Each stage takes the value of the stage before it; stage 0 takes the input.
    always_comb begin
        stage_d[0] = d_in;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Synchronizer flops with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= {W{1'b0}};
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_out = stage_q[STAGES-1];

endmodule

// File: rtl/gray_decoder_monitor.sv
// Receive side of a Gray-counter link: synchronizes the incoming Gray count,
// decodes it to binary and classifies each sampled change as +1, -1 or an
// illegal skip, counting skips in a saturating error counter.
module gray_decoder_monitor
    import gray_pkg::*;
#(
    parameter int N           = GRAY_DEFAULT_W,
    parameter int SYNC_STAGES = 2,
    parameter int ERRW        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    gray_in,
    input  logic            sample_en,
    input  logic            err_clr,
    output logic [N-1:0]    bin_out,
    output logic            bin_valid,
    output logic            step_up,
    output logic            step_down,
    output logic            skip_err,
    output logic [ERRW-1:0] err_count
);

    logic [N-1:0]    gray_sync_s;
    logic [N-1:0]    bin_s;
    logic [N-1:0]    diff_s;
    step_kind_e      kind_s;

    logic [N-1:0]    bin_out_q,   bin_out_d;
    logic            bin_valid_q, bin_valid_d;
    logic            step_up_q,   step_up_d;
    logic            step_down_q, step_down_d;
    logic            skip_err_q,  skip_err_d;
    logic [ERRW-1:0] err_count_q, err_count_d;

    gray_sync #(
        .W      (N),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (gray_in),
        .q_out (gray_sync_s)
    );

    // Decode the synchronized Gray value and measure the step from the last sample.
    always_comb begin
        bin_s  = N'(gray2bin(GRAY_MAX_W'(gray_sync_s)));
        diff_s = bin_s - bin_out_q;
        if (diff_s == {N{1'b0}}) begin
            kind_s = STEP_NONE;
        end else if (diff_s == N'(1)) begin
            kind_s = STEP_UP;
        end else if (diff_s == {N{1'b1}}) begin
            kind_s = STEP_DOWN;
        end else begin
            kind_s = STEP_SKIP;
        end
    end

    // Next-state: capture the sample, raise at most one pulse, update error count.
    always_comb begin
        bin_out_d   = bin_out_q;
        bin_valid_d = bin_valid_q;
        step_up_d   = 1'b0;
        step_down_d = 1'b0;
        skip_err_d  = 1'b0;

        if (sample_en) begin
            bin_out_d = bin_s;
            if (!bin_valid_q) begin
                // Priming sample: nothing to compare against yet.
                bin_valid_d = 1'b1;
            end else begin
                case (kind_s)
                    STEP_NONE: ;
                    STEP_UP:   step_up_d   = 1'b1;
                    STEP_DOWN: step_down_d = 1'b1;
                    STEP_SKIP: skip_err_d  = 1'b1;
                    default:   skip_err_d  = 1'b1;
                endcase
            end
        end else begin
            bin_out_d   = bin_out_q;
            bin_valid_d = bin_valid_q;
        end

        // Clear wins over an increment in the same cycle.
        if (err_clr) begin
            err_count_d = {ERRW{1'b0}};
        end else if (skip_err_d && (err_count_q != {ERRW{1'b1}})) begin
            err_count_d = err_count_q + ERRW'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_out_q   <= {N{1'b0}};
            bin_valid_q <= 1'b0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            skip_err_q  <= 1'b0;
            err_count_q <= {ERRW{1'b0}};
        end else begin
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            step_up_q   <= step_up_d;
            step_down_q <= step_down_d;
            skip_err_q  <= skip_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign bin_valid = bin_valid_q;
    assign step_up   = step_up_q;
    assign step_down = step_down_q;
    assign skip_err  = skip_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_decoder_monitor.sv
// Directed testbench for gray_decoder_monitor at default parameters.
// Observed outputs are packed as {bin_out, bin_valid, step_up, step_down,
// skip_err, err_count} and compared against hand-computed vectors.
module tb_gray_decoder_monitor;

    localparam int N    = 8;
    localparam int ERRW = 8;
    localparam int VW   = N + 4 + ERRW;

    logic            clk;
    logic            rst;
    logic [N-1:0]    gray_in;
    logic            sample_en;
    logic            err_clr;
    logic [N-1:0]    bin_out;
    logic            bin_valid;
    logic            step_up;
    logic            step_down;
    logic            skip_err;
    logic [ERRW-1:0] err_count;

    logic [VW-1:0]   obs;
    logic [VW-1:0]   ev;
    int              checks;
    int              errors;

    gray_decoder_monitor #(
        .N           (N),
        .SYNC_STAGES (2),
        .ERRW        (ERRW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .sample_en (sample_en),
        .err_clr   (err_clr),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .step_up   (step_up),
        .step_down (step_down),
        .skip_err  (skip_err),
        .err_count (err_count)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {bin_out, bin_valid, step_up, step_down, skip_err, err_count};

    function automatic logic [VW-1:0] exp_v(input logic [N-1:0] b, input logic v,
                                            input logic u, input logic d,
                                            input logic s, input logic [ERRW-1:0] e);
        return {b, v, u, d, s, e};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a Gray value long enough to cross the synchronizer and be sampled.
    task automatic apply_gray(input logic [N-1:0] g);
        gray_in = g;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; gray_in = 8'h00; sample_en = 1'b0; err_clr = 1'b0;
        #1;
        ev = exp_v(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL reset_asserted: got %h expected %h", obs, ev); end
        tick(); tick();
        ev = exp_v(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL reset_held: got %h expected %h", obs, ev); end
        #2 rst = 1'b0;
        gray_in = 8'h00; sample_en = 1'b1;
        repeat (3) tick();
        ev = exp_v(8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL priming: got %h expected %h", obs, ev); end
    endtask

    task automatic test_count_up();
        logic [N-1:0] gv [3];
        logic [N-1:0] eb [5];
        logic         eu [5];
        gv[0] = 8'h01; gv[1] = 8'h03; gv[2] = 8'h02;
        eb[0] = 8'd0; eb[1] = 8'd0; eb[2] = 8'd1; eb[3] = 8'd2; eb[4] = 8'd3;
        eu[0] = 1'b0; eu[1] = 1'b0; eu[2] = 1'b1; eu[3] = 1'b1; eu[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) gray_in = gv[i];
            tick();
            ev = exp_v(eb[i], 1'b1, eu[i], 1'b0, 1'b0, 8'd0);
            checks++;
            if (obs !== ev) begin errors++; $display("FAIL count_up[%0d]: got %h expected %h", i, obs, ev); end
        end
        tick();
        ev = exp_v(8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL count_up_settle: got %h expected %h", obs, ev); end
    endtask

    task automatic test_wrap();
        rst = 1'b1; sample_en = 1'b0; gray_in = 8'h80;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        sample_en = 1'b1;
        tick();
        ev = exp_v(8'd255, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL wrap_prime: got %h expected %h", obs, ev); end
        apply_gray(8'h00);
        ev = exp_v(8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL wrap_up: got %h expected %h", obs, ev); end
        apply_gray(8'h80);
        ev = exp_v(8'd255, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL wrap_down: got %h expected %h", obs, ev); end
        tick();
        ev = exp_v(8'd255, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL wrap_pulse_len: got %h expected %h", obs, ev); end
    endtask

    task automatic test_skip_saturation();
        apply_gray(8'h00);
        apply_gray(8'h01);
        ev = exp_v(8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL skip_pre_step: got %h expected %h", obs, ev); end
        apply_gray(8'h02);
        ev = exp_v(8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL skip_first: got %h expected %h", obs, ev); end
        // Alternate bin 0 / bin 3 every cycle: every sample is a skip.
        for (int i = 0; i < 300; i++) begin
            gray_in = (i % 2 == 1) ? 8'h00 : 8'h02;
            tick();
        end
        checks++;
        if (err_count !== 8'd255) begin errors++; $display("FAIL skip_saturate: got %0d expected 255", err_count); end
        apply_gray(8'h00);
        ev = exp_v(8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL skip_sat_hold: got %h expected %h", obs, ev); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        ev = exp_v(8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL err_clr: got %h expected %h", obs, ev); end
        gray_in = 8'h02;
        tick(); tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        ev = exp_v(8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL clr_with_skip: got %h expected %h", obs, ev); end
        tick();
        ev = exp_v(8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL clr_skip_after: got %h expected %h", obs, ev); end
    endtask

    task automatic test_gated_sampling();
        logic [N-1:0] walk [3];
        walk[0] = 8'h07; walk[1] = 8'h05; walk[2] = 8'h04;
        apply_gray(8'h06);
        ev = exp_v(8'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL gate_start: got %h expected %h", obs, ev); end
        sample_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) gray_in = walk[i];
            tick();
            ev = exp_v(8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
            checks++;
            if (obs !== ev) begin errors++; $display("FAIL gate_hold[%0d]: got %h expected %h", i, obs, ev); end
        end
        sample_en = 1'b1;
        tick();
        ev = exp_v(8'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL gate_resume: got %h expected %h", obs, ev); end
    endtask

    task automatic test_midstream_reset();
        apply_gray(8'h00);
        apply_gray(8'h04);
        apply_gray(8'h00);
        apply_gray(8'h04);
        ev = exp_v(8'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL mid_pre: got %h expected %h", obs, ev); end
        #2 rst = 1'b1;
        #1;
        ev = exp_v(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL mid_async: got %h expected %h", obs, ev); end
        sample_en = 1'b0;
        gray_in = 8'h04;
        tick();
        rst = 1'b0;
        tick(); tick();
        ev = exp_v(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL mid_released: got %h expected %h", obs, ev); end
        sample_en = 1'b1;
        tick();
        ev = exp_v(8'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL mid_reprime: got %h expected %h", obs, ev); end
        tick();
        ev = exp_v(8'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (obs !== ev) begin errors++; $display("FAIL mid_steady: got %h expected %h", obs, ev); end
    endtask

    // Run every scenario in order and report.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_count_up();
        test_wrap();
        test_skip_saturation();
        test_gated_sampling();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_decoder_monitor.md
# gray_decoder_monitor

Receive-side companion to the N-bit Gray counter. The block samples a Gray-coded count that may come from another clock domain, synchronizes it, converts it to binary, and classifies each sampled change as a single step up, a single step down, or an illegal multi-step skip. A saturating error counter tracks the skips. It sits between a Gray-counter source and any consumer that needs a binary count plus a direction and integrity indication.

## Interface
- N, default 8: Gray/binary word width (N ≥ 2).
- SYNC_STAGES, default 2: synchronizer flop depth (≥ 2).
- ERRW, default 8: error counter width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- gray_in  in  N  Gray-coded count, possibly asynchronous to clk.
- sample_en  in  1  when 1, the synchronized value is decoded and evaluated this cycle.
- err_clr  in  1  synchronous clear of err_count.
- bin_out  out  N  last sampled value, binary.
- bin_valid  out  1  high once the first sample after reset has been taken.
- step_up  out  1  one-cycle pulse: new value = previous + 1 (mod 2^N).
- step_down  out  1  one-cycle pulse: new value = previous − 1 (mod 2^N).
- skip_err  out  1  one-cycle pulse: new value differs by any amount other than 0 or ±1.
- err_count  out  ERRW  number of skip_err events, saturating at 2^ERRW − 1.

## Operation
- Synchronizer: gray_in passes through a SYNC_STAGES-deep flop chain. Every stage resets to 0.
- Decode (combinational on synchronizer output): b[N−1] = g[N−1]; b[i] = b[i+1] ^ g[i] for i = N−2 down to 0.
- On a cycle with sample_en = 1:
  - bin_out ← b.
  - If bin_valid = 0 (first sample): set bin_valid = 1. No step or error pulse.
  - Otherwise compute d = b − bin_out mod 2^N:
    - d = 0: no pulse.
    - d = 1: step_up.
    - d = 2^N − 1: step_down.
    - Any other d: skip_err, and err_count increments if not saturated.
- sample_en = 0: bin_out and bin_valid hold, all pulses stay 0, and the synchronizer keeps running. The next enabled sample is compared against the last sampled value, so intermediate changes it never saw can produce a skip_err.
- Wrap-around is legal in both directions: 2^N−1 → 0 is step_up, and 0 → 2^N−1 is step_down.
- err_clr has priority over increment. When err_clr = 1 in the same cycle as a skip, err_count = 0 and skip_err still pulses.
- At most one of step_up, step_down, skip_err is high in any cycle.

## Timing
- Reset values: bin_out = 0, bin_valid = 0, step_up = step_down = skip_err = 0, err_count = 0, synchronizer = 0.
- rst takes effect immediately (asynchronous) and may be asserted mid-stream. After release, the first sample is again a priming sample.
- Latency: a gray_in change meeting setup before edge k appears on bin_out after edge k + SYNC_STAGES, provided sample_en = 1 at that edge. That is 3 cycles at the default depth.
- Pulses are registered, asserted in the same cycle bin_out updates, and last exactly one cycle.
- err_count updates on the same edge as skip_err.
- err_clr is effective at the next edge.

## Structure
- Shared package/header `gray_pkg`:
  - gray-to-binary function (parameterized width).
  - binary-to-gray function, shared with the counter side.
  - default width constant.
- Sub-module `gray_sync`: a parameterized N-bit, SYNC_STAGES-deep synchronizer with async reset, reusable by other CDC paths.
- Top level holds decode, the compare/classify register stage and the error counter.

## Test plan
- Reset/priming: rst pulse, then gray_in = 0x00 with sample_en = 1 → bin_out = 0x00 and bin_valid = 1 after 3 edges. No pulses. All outputs were 0 during reset.
- Count up: gray_in = 0x00, 0x01, 0x03, 0x02, one per cycle, sample_en = 1 → bin_out = 0, 1, 2, 3 with step_up on each of the last three samples. Latency is 3 cycles.
- Wrap: gray_in = 0x80 (bin 255) then 0x00 → step_up. Then 0x00 → 0x80 → step_down. err_count stays 0.
- Skip and saturation: 0x01 → 0x02 (bin 1 → 3) → skip_err and err_count = 1. Apply 300 more skips → err_count = 255 and held. err_clr → 0 next edge. err_clr together with a skip → skip_err pulses, err_count = 0.
- Gated sampling: sample_en = 0 while gray_in walks bin 4 → 7 → bin_out stays 4, no pulses. sample_en = 1 → bin_out = 7 with skip_err.
- Mid-operation reset: with err_count = 5 and bin_valid = 1, assert rst between edges → all outputs 0 immediately. The first sample after release gives no pulse.
